// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide controller: fixed-latency mult/div sequencing,
// mthi/mtlo writes and the D-stage HI/LO hazard stall.
`timescale 1ns/1ps
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [2:0]  opE,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        mdD,
  output logic        busy,
  output logic        stallMD,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        start_md;
  logic [63:0] sprod, uprod, res;
  logic [31:0] squot, srem, uquot, urem;
  logic        res_we;

  // opE 000-011 are the multi-cycle operations
  assign start_md = startE && !opE[2];
  assign busy     = (state_q == RUN);
  assign stallMD  = mdD && (busy || start_md);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    sprod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    uprod = {32'b0, a_q} * {32'b0, b_q};
    squot = '0;
    srem  = '0;
    uquot = '0;
    urem  = '0;
    if (b_q != '0) begin
      // Signed overflow case is pinned explicitly rather than left to the divider
      if (a_q == 32'h8000_0000 && b_q == '1) begin
        squot = 32'h8000_0000;
        srem  = '0;
      end else begin
        squot = 32'($signed(a_q) / $signed(b_q));
        srem  = 32'($signed(a_q) % $signed(b_q));
      end
      uquot = a_q / b_q;
      urem  = a_q % b_q;
    end

    res_we = 1'b0;
    res    = '0;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1;          res = sprod;        end
      OP_MULTU: begin res_we = 1'b1;          res = uprod;        end
      OP_DIV:   begin res_we = (b_q != '0);   res = {srem, squot}; end
      OP_DIVU:  begin res_we = (b_q != '0);   res = {urem, uquot}; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_md) begin
          a_d     = srcA;
          b_d     = srcB;
          op_d    = opE;
          cnt_d   = opE[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else if (startE && opE == OP_MTHI) begin
          hi_d = srcA;
        end else if (startE && opE == OP_MTLO) begin
          lo_d = srcA;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (res_we) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes model expectations,
// a negedge monitor pops them and checks busy/stall/HI/LO timing.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0;
  logic [2:0]  opE = '0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        mdD = 1'b0;
  logic        busy, stallMD;
  logic [31:0] hi, lo;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcA(srcA), .srcB(srcB), .mdD(mdD),
    .busy(busy), .stallMD(stallMD), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_reset;
    int          start;
    int          lat;
    logic        md;
    logic        sstall;
    logic [31:0] ohi, olo, ehi, elo;
  } exp_t;

  exp_t q[$];
  logic [31:0] mhi = '0, mlo = '0;
  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: architectural HI/LO effect and busy length of one operation
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
    ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
    lat = 0;
    case (op)
      3'd0: begin lat = MC; sq = sa * sb; mhi = sq[63:32]; mlo = sq[31:0]; end
      3'd1: begin lat = MC; up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; end
      3'd2: begin
        lat = DC;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0]; end
      end
      3'd3: begin
        lat = DC;
        if (b != 0) begin mlo = 32'(ua / ub); mhi = 32'(ua % ub); end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      startE = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic md, input bit dopoke, input logic [2:0] pop, input bit nowait);
    exp_t e;
    int lat, poke;
    if (!nowait) begin @(posedge clk); #1; end
    startE = 1'b1; opE = op; srcA = a; srcB = b; mdD = md;
    e.is_reset = 1'b0;
    e.ohi = mhi; e.olo = mlo;
    model(op, a, b, lat);
    e.ehi = mhi; e.elo = mlo;
    e.lat = lat; e.start = cyc + 1; e.md = md;
    e.sstall = md && (op < 3'd4);
    q.push_back(e);
    @(posedge clk); #1;
    startE = 1'b0; opE = 3'($urandom); srcA = $urandom; srcB = $urandom;
    poke = (dopoke && lat >= 3) ? int'($urandom_range(lat - 3)) : -1;
    for (int i = 0; i < lat - 1; i++) begin
      @(posedge clk); #1;
      startE = (i == poke);
      opE = pop;
    end
  endtask

  task automatic do_reset(input int quiet);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1; startE = 1'b0;
    e.is_reset = 1'b1; e.start = cyc; e.lat = quiet; e.md = 1'b0; e.sstall = 1'b0;
    e.ohi = '0; e.olo = '0; e.ehi = '0; e.elo = '0;
    q.push_back(e);
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    if (quiet > 0) idle(quiet);
  endtask

  exp_t cur;
  bit   have = 1'b0;
  bit   fin;

  task automatic step(output bit done);
    int rel;
    rel = cyc - cur.start;
    done = 1'b0;
    if (cur.is_reset) begin
      chk("rst_busy", 32'(busy), 32'(0));
      if (rel == 0 || rel >= cur.lat) begin
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
      end
      done = (rel >= cur.lat);
    end else if (rel < 0) begin
      chk("start_stall", 32'(stallMD), 32'(cur.sstall));
      chk("start_busy", 32'(busy), 32'(0));
    end else if (rel < cur.lat) begin
      chk("run_busy", 32'(busy), 32'(1));
      chk("run_stall", 32'(stallMD), 32'(cur.md));
      if (rel == cur.lat - 1) begin
        chk("hold_hi", hi, cur.ohi);
        chk("hold_lo", lo, cur.olo);
      end
    end else begin
      chk("done_busy", 32'(busy), 32'(0));
      chk("result_hi", hi, cur.ehi);
      chk("result_lo", lo, cur.elo);
      chk("done_stall", 32'(stallMD), 32'(mdD && startE && (opE < 3'd4)));
      done = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!have && q.size() > 0) begin cur = q.pop_front(); have = 1'b1; end
    if (have) begin
      step(fin);
      if (fin) begin
        have = 1'b0;
        if (q.size() > 0) begin
          cur = q.pop_front(); have = 1'b1;
          step(fin);
          if (fin) have = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    do_reset(0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 3'd0, 1'b1);
    idle(1);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 3'd2, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 3'd0, 1'b0);
    issue(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, 1'b0);
    issue(3'd4, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    issue(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b1, 1'b0, 3'd0, 1'b0);
    issue(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 3'd0, 1'b0);
    issue(3'd0, 32'd7, 32'd9, 1'b0, 1'b1, 3'd4, 1'b0);
    // div aborted by reset in its third busy cycle
    @(posedge clk); #1;
    startE = 1'b1; opE = 3'd2; srcA = 32'd100; srcB = 32'd7; mdD = 1'b0;
    @(posedge clk); #1;
    startE = 1'b0;
    @(posedge clk); #1;
    do_reset(DC + 1);
    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(7)), pick(), pick(), 1'($urandom), 1'($urandom_range(3) == 0),
            3'($urandom), 1'b0);
    end
    idle(3);
    for (int i = 0; i < 200 && (q.size() != 0 || have); i++) @(negedge clk);
    checks++;
    if (q.size() != 0 || have) begin
      fails++;
      $display("FAIL drain: %0d entries pending, expected 0", q.size() + int'(have));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
